// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback path.
package uart_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DROP_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_push_s;
   logic              do_pop_s;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == (AW+1)'(0));
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Next-state pointers and occupancy.
   always_comb begin
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= AW'(0);
         rd_ptr_q <= AW'(0);
         count_q  <= (AW+1)'(0);
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/loopback_ctrl.sv
// Buffers received bytes and hands them to the UART transmitter one at a time
// via a start/busy handshake; tracks sticky overrun and a saturating drop count.
module loopback_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     rx_data_ready,
   input  logic [DATA_W-1:0]        rx_data,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     overrun_clr,
   output logic                     overrun,
   output logic [DROP_W-1:0]        drop_count,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   state_e              state_q, state_d;
   logic                tx_start_q, tx_start_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                overrun_q, overrun_d;
   logic [DROP_W-1:0]   drop_count_q, drop_count_d;
   logic                pop_s;
   logic                drop_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [DATA_W-1:0]   fifo_rdata_s;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_data_ready),
      .pop   (pop_s),
      .wdata (rx_data),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count)
   );

   // Transmit sequencing; the head byte is latched on the pop so it stays stable for the whole frame.
   always_comb begin
      state_d   = state_q;
      pop_s     = 1'b0;
      tx_data_d = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && !fifo_empty_s) begin
               pop_s     = 1'b1;
               tx_data_d = fifo_rdata_s;
               state_d   = ST_START;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_START: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else begin
               state_d = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      tx_start_d = (state_d == ST_START);
   end

   // Overrun bookkeeping; a clear in the same cycle as a drop discards that drop.
   always_comb begin
      drop_s       = rx_data_ready && fifo_full_s && !pop_s;
      overrun_d    = overrun_q;
      drop_count_d = drop_count_q;
      if (overrun_clr) begin
         overrun_d    = 1'b0;
         drop_count_d = DROP_W'(0);
      end else if (drop_s) begin
         overrun_d = 1'b1;
         if (drop_count_q != {DROP_W{1'b1}}) begin
            drop_count_d = drop_count_q + DROP_W'(1);
         end else begin
            drop_count_d = drop_count_q;
         end
      end else begin
         overrun_d    = overrun_q;
         drop_count_d = drop_count_q;
      end
   end

   // Controller registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tx_start_q   <= 1'b0;
         tx_data_q    <= DATA_W'(0);
         overrun_q    <= 1'b0;
         drop_count_q <= DROP_W'(0);
      end else begin
         state_q      <= state_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         overrun_q    <= overrun_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign overrun    = overrun_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_loopback_ctrl.sv
// Self-checking bench for loopback_ctrl: a behavioural transmitter plus a byte-queue reference model.
module tb_loopback_ctrl;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       rx_data_ready;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       overrun_clr;
   logic       overrun;
   logic [7:0] drop_count;
   logic [3:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // transmitter model state
   logic [7:0] sent_q[$];
   int         start_cnt   = 0;
   int         busy_len    = 10;
   int         busy_delay  = 0;
   int         fall_cyc    = 0;
   bit         have_fall   = 0;
   bit         xmit_active = 0;
   bit         aborted     = 0;
   logic [7:0] cap;

   // reference model
   logic [7:0] exp_q[$];
   int         exp_drops;

   loopback_ctrl #(.DATA_W(8), .DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .rx_data_ready (rx_data_ready),
      .rx_data       (rx_data),
      .tx_busy       (tx_busy),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .overrun_clr   (overrun_clr),
      .overrun       (overrun),
      .drop_count    (drop_count),
      .fifo_count    (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Transmitter: captures the byte on tx_start, raises busy after busy_delay cycles, holds it busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            xmit_active = 1;
            aborted     = 0;
            cap         = tx_data;
            sent_q.push_back(cap);
            start_cnt++;
            if (have_fall) begin
               n_checks++;
               if (cyc - fall_cyc < 2) begin
                  n_fail++;
                  $display("FAIL start_gap: got %0d cycles after busy fell, required >= 2", cyc - fall_cyc);
               end
            end
            for (int d = 0; d < busy_delay; d++) begin
               @(negedge clk);
               n_checks++;
               if (tx_start !== 1'b0) begin
                  n_fail++;
                  $display("FAIL start_width: tx_start=%b one cycle after start, required 0", tx_start);
               end
            end
            tx_busy = 1'b1;
            for (int b = 0; b < busy_len; b++) begin
               @(negedge clk);
               if (rst) aborted = 1;
               if (!aborted) begin
                  n_checks++;
                  if (tx_data !== cap) begin
                     n_fail++;
                     $display("FAIL tx_data_stable: got %02h during frame, required %02h", tx_data, cap);
                  end
               end
            end
            tx_busy     = 1'b0;
            fall_cyc    = cyc;
            have_fall   = 1;
            xmit_active = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   task automatic push_byte(input logic [7:0] b);
      rx_data_ready = 1'b1;
      rx_data       = b;
      @(negedge clk);
      rx_data_ready = 1'b0;
   endtask

   // model: push a byte into the expected queue while the FIFO cannot drain
   task automatic model_push(input logic [7:0] b);
      if (exp_q.size() < 8) exp_q.push_back(b);
      else exp_drops++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sent_q.delete();
      exp_q.delete();
      exp_drops = 0;
      start_cnt = 0;
   endtask

   task automatic wait_sent(input int n, input int budget);
      int k = 0;
      while ((sent_q.size() < n || xmit_active || tx_busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= budget) begin
         n_fail++;
         $display("FAIL wait_timeout: got %0d bytes sent, required %0d within %0d cycles", sent_q.size(), n, budget);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (tx_start !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
      n_checks++; if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL reset_tx_data: got %02h required 00", tx_data); end
      n_checks++; if (overrun !== 1'b0)     begin n_fail++; $display("FAIL reset_overrun: got %b required 0", overrun); end
      n_checks++; if (drop_count !== 8'd0)  begin n_fail++; $display("FAIL reset_drop_count: got %0d required 0", drop_count); end
      n_checks++; if (fifo_count !== 4'd0)  begin n_fail++; $display("FAIL reset_fifo_count: got %0d required 0", fifo_count); end
   endtask

   task automatic test_single();
      enable = 1'b1; busy_len = 10; busy_delay = 0;
      push_byte(8'hA5);
      n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count_n1: got %0d required 1", fifo_count); end
      n_checks++; if (tx_start !== 1'b0)   begin n_fail++; $display("FAIL single_start_n1: got %b required 0", tx_start); end
      @(negedge clk);
      n_checks++; if (tx_start !== 1'b1)   begin n_fail++; $display("FAIL single_start_n2: got %b required 1", tx_start); end
      n_checks++; if (tx_data !== 8'hA5)   begin n_fail++; $display("FAIL single_data_n2: got %02h required a5", tx_data); end
      wait_sent(1, 100);
      n_checks++;
      if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin
         n_fail++; $display("FAIL single_sent: got %0d bytes, required one byte a5", sent_q.size());
      end
      n_checks++; if (start_cnt != 1)      begin n_fail++; $display("FAIL single_start_cnt: got %0d required 1", start_cnt); end
      n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_count_end: got %0d required 0", fifo_count); end
   endtask

   task automatic test_burst();
      sent_q.delete(); start_cnt = 0;
      busy_len = 20; busy_delay = $urandom_range(0, 3);
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      wait_sent(8, 400);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (i >= sent_q.size() || sent_q[i] !== 8'(i + 1)) begin
            n_fail++; $display("FAIL burst_order[%0d]: got %02h required %02h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, 8'(i + 1));
         end
      end
      n_checks++; if (start_cnt != 8)    begin n_fail++; $display("FAIL burst_start_cnt: got %0d required 8", start_cnt); end
      n_checks++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL burst_overrun: got %b required 0", overrun); end
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      sent_q.delete(); exp_q.delete(); exp_drops = 0;
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         b = 8'($urandom);
         push_byte(b);
         model_push(b);
      end
      n_checks++; if (fifo_count !== 4'(exp_q.size())) begin n_fail++; $display("FAIL ovf_count: got %0d required %0d", fifo_count, exp_q.size()); end
      n_checks++; if (overrun !== 1'b1)                begin n_fail++; $display("FAIL ovf_overrun: got %b required 1", overrun); end
      n_checks++; if (drop_count !== 8'(exp_drops))    begin n_fail++; $display("FAIL ovf_drops: got %0d required %0d", drop_count, exp_drops); end
      enable = 1'b1; busy_len = 3; busy_delay = $urandom_range(0, 3);
      wait_sent(8, 300);
      n_checks++; if (sent_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_sent_cnt: got %0d required %0d", sent_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
         n_checks++;
         if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_order[%0d]: got %02h required %02h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] b;
      sent_q.delete(); exp_q.delete();
      overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
      n_checks++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL clr: got overrun=%b drops=%0d required 0/0", overrun, drop_count); end
      enable = 1'b0; busy_len = 5; busy_delay = 1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         push_byte(b);
         exp_q.push_back(b);
      end
      b = 8'($urandom);
      enable = 1'b1; rx_data_ready = 1'b1; rx_data = b;
      @(negedge clk);
      enable = 1'b0; rx_data_ready = 1'b0;
      exp_q.push_back(b);
      n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL pp_count: got %0d required 8", fifo_count); end
      n_checks++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL pp_nodrop: got overrun=%b drops=%0d required 0/0", overrun, drop_count); end
      wait_sent(1, 100);
      n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL pp_count_hold: got %0d required 8", fifo_count); end
      push_byte(8'h5A);
      n_checks++; if (overrun !== 1'b1 || drop_count !== 8'd1) begin n_fail++; $display("FAIL pp_drop: got overrun=%b drops=%0d required 1/1", overrun, drop_count); end
      overrun_clr = 1'b1; rx_data_ready = 1'b1; rx_data = 8'h3C;
      @(negedge clk);
      overrun_clr = 1'b0; rx_data_ready = 1'b0;
      n_checks++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL clr_wins: got overrun=%b drops=%0d required 0/0", overrun, drop_count); end
      enable = 1'b1;
      wait_sent(9, 500);
      n_checks++; if (sent_q.size() != 9) begin n_fail++; $display("FAIL pp_sent_cnt: got %0d required 9", sent_q.size()); end
      for (int i = 0; i < 9 && i < sent_q.size(); i++) begin
         n_checks++;
         if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pp_order[%0d]: got %02h required %02h", i, sent_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_saturate();
      enable = 1'b0;
      for (int i = 0; i < 262; i++) push_byte(8'($urandom));
      n_checks++; if (drop_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d required 254", drop_count); end
      push_byte(8'($urandom));
      n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d required 255", drop_count); end
      for (int i = 0; i < 37; i++) push_byte(8'($urandom));
      n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d required 255", drop_count); end
      n_checks++; if (fifo_count !== 4'd8 || overrun !== 1'b1) begin n_fail++; $display("FAIL sat_state: got count=%0d overrun=%b required 8/1", fifo_count, overrun); end
      do_reset();
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int starts_before;
      enable = 1'b1; busy_len = 30; busy_delay = 0;
      for (int i = 0; i < 4; i++) push_byte(8'($urandom));
      while (tx_busy !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      n_checks++; if (k >= 50) begin n_fail++; $display("FAIL rm_busy_timeout: got no busy, required busy within 50 cycles"); end
      repeat (3) @(negedge clk);
      n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL rm_queued: got %0d required 3", fifo_count); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rm_count: got %0d required 0", fifo_count); end
      n_checks++; if (tx_start !== 1'b0)   begin n_fail++; $display("FAIL rm_start: got %b required 0", tx_start); end
      n_checks++; if (tx_data !== 8'h00)   begin n_fail++; $display("FAIL rm_data: got %02h required 00", tx_data); end
      rst = 1'b0;
      starts_before = start_cnt;
      repeat (60) @(negedge clk);
      n_checks++; if (start_cnt != starts_before) begin n_fail++; $display("FAIL rm_no_tx: got %0d starts required %0d", start_cnt, starts_before); end
      n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rm_count_after: got %0d required 0", fifo_count); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int n;
      int exp_sat;
      for (int it = 0; it < 3; it++) begin
         enable = 1'b0;
         do_reset();
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            push_byte(b);
            model_push(b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         exp_sat = (exp_drops > 255) ? 255 : exp_drops;
         n_checks++; if (fifo_count !== 4'(exp_q.size()))  begin n_fail++; $display("FAIL rnd_count: got %0d required %0d", fifo_count, exp_q.size()); end
         n_checks++; if (drop_count !== 8'(exp_sat))       begin n_fail++; $display("FAIL rnd_drops: got %0d required %0d", drop_count, exp_sat); end
         n_checks++; if (overrun !== (exp_drops > 0))      begin n_fail++; $display("FAIL rnd_overrun: got %b required %b", overrun, exp_drops > 0); end
         busy_len = $urandom_range(1, 12); busy_delay = $urandom_range(0, 3);
         enable = 1'b1;
         wait_sent(exp_q.size(), 600);
         n_checks++; if (sent_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_sent_cnt: got %0d required %0d", sent_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            n_checks++;
            if (sent_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_order[%0d]: got %02h required %02h", i, sent_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; rx_data_ready = 1'b0; rx_data = 8'h00; overrun_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_push_pop();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
